tlb_assoc: RTL and testbench

TLB_ASSOC -- requirements
Module: tlb_assoc

---
 rtl/tlb_pkg.sv | 12 +
 rtl/tlb_victim_sel.sv | 37 +++
 rtl/tlb_assoc.sv | 139 +++++++++++++
 tb/tb_tlb_assoc.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types and constants for the fully-associative TLB.
// Holds the walk FSM encoding and the pattern driven on a miss.
package tlb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WALK = 1'b1
  } tlb_state_e;

  localparam logic [31:0] TLB_MISS_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/tlb_victim_sel.sv
// Picks the entry to refill: lowest-index invalid entry, else a round-robin
// pointer that only moves when a valid entry is actually replaced.
module tlb_victim_sel #(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ENTRIES-1:0] valid,
  input  logic               fill,
  output logic [IDX_W-1:0]   victim_idx
);

  logic [IDX_W-1:0] rr_ptr_reg;
  logic             found;

  always_comb begin
    victim_idx = rr_ptr_reg;
    found      = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!valid[i] && !found) begin
        victim_idx = IDX_W'(i);
        found      = 1'b1;
      end
    end
  end

  // ENTRIES is a power of two, so natural wrap gives the modulo.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
    end else if (fill && (&valid)) begin
      rr_ptr_reg <= rr_ptr_reg + IDX_W'(1);
    end
  end

endmodule

// File: rtl/tlb_assoc.sv
// Fully-associative TLB with combinational lookup and a fixed-latency
// refill walk that synthesises PPN = VPN + PPN_OFFSET.
module tlb_assoc
  import tlb_pkg::*;
#(
  parameter int ENTRIES      = 4,
  parameter int PAGE_BITS    = 10,
  parameter int MISS_LATENCY = 10,
  parameter int PPN_OFFSET   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] virt_addr_in,
  input  logic        flush,
  output logic [31:0] phys_addr_out,
  output logic        hit,
  output logic        tlb_stall,
  output logic [15:0] miss_count
);

  localparam int               VPN_W   = 32 - PAGE_BITS;
  localparam int               IDX_W   = $clog2(ENTRIES);
  localparam logic [VPN_W-1:0] PPN_ADD = VPN_W'(PPN_OFFSET);
  localparam logic [3:0]       LAT     = 4'(MISS_LATENCY);

  tlb_state_e        state_reg, state_next;
  logic [3:0]        counter_reg, counter_next;
  logic [VPN_W-1:0]  walk_vpn_reg, walk_vpn_next;
  logic [15:0]       miss_count_reg, miss_count_next;
  logic [ENTRIES-1:0] valid_reg;
  logic [VPN_W-1:0]  vpn_reg [ENTRIES];
  logic [VPN_W-1:0]  ppn_reg [ENTRIES];

  logic [VPN_W-1:0]   vpn_in;
  logic [ENTRIES-1:0] match;
  logic               any_match;
  logic [VPN_W-1:0]   hit_ppn;
  logic               fill;
  logic [IDX_W-1:0]   victim_idx;

  assign vpn_in = virt_addr_in[31:PAGE_BITS];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
    assign match[gi] = valid_reg[gi] && (vpn_reg[gi] == vpn_in);
  end

  // VPNs are unique, so OR-ing the matching PPNs yields the single hit.
  always_comb begin
    hit_ppn = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (match[i]) hit_ppn = hit_ppn | ppn_reg[i];
    end
  end

  assign any_match     = |match;
  assign hit           = req_valid && (state_reg == IDLE) && any_match;
  assign phys_addr_out = hit ? {hit_ppn, virt_addr_in[PAGE_BITS-1:0]} : TLB_MISS_PATTERN;
  assign miss_count    = miss_count_reg;

  always_comb begin
    state_next      = state_reg;
    counter_next    = counter_reg;
    walk_vpn_next   = walk_vpn_reg;
    miss_count_next = miss_count_reg;
    fill            = 1'b0;
    tlb_stall       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flush) begin
          tlb_stall = 1'b1;
        end else if (req_valid && !any_match) begin
          tlb_stall       = 1'b1;
          walk_vpn_next   = vpn_in;
          counter_next    = '0;
          miss_count_next = (miss_count_reg == 16'hFFFF) ? miss_count_reg
                                                         : miss_count_reg + 16'd1;
          state_next      = WALK;
        end
      end
      WALK: begin
        tlb_stall = 1'b1;
        if (flush) begin
          counter_next = '0;
          state_next   = IDLE;
        end else if (counter_reg == LAT) begin
          fill         = 1'b1;
          counter_next = '0;
          state_next   = IDLE;
        end else begin
          counter_next = counter_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      counter_reg    <= '0;
      walk_vpn_reg   <= '0;
      miss_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      counter_reg    <= counter_next;
      walk_vpn_reg   <= walk_vpn_next;
      miss_count_reg <= miss_count_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        vpn_reg[i] <= '0;
        ppn_reg[i] <= '0;
      end
    end else if (flush) begin
      valid_reg <= '0;
    end else if (fill) begin
      valid_reg[victim_idx] <= 1'b1;
      vpn_reg[victim_idx]   <= walk_vpn_reg;
      ppn_reg[victim_idx]   <= walk_vpn_reg + PPN_ADD;
    end
  end

  tlb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim_sel (
    .clock      (clock),
    .reset      (reset),
    .valid      (valid_reg),
    .fill       (fill),
    .victim_idx (victim_idx)
  );

endmodule

// File: tb/tb_tlb_assoc.sv
// Directed bench for tlb_assoc: default instance plus a PPN_OFFSET=1 twin
// driven by the same inputs.
module tb_tlb_assoc;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic [31:0] virt_addr_in;
  logic        flush;
  logic [31:0] phys_addr_out, phys2;
  logic        hit, hit2;
  logic        tlb_stall, stall2;
  logic [15:0] miss_count, miss_count2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_mc  = 0;

  tlb_assoc dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .virt_addr_in  (virt_addr_in),
    .flush         (flush),
    .phys_addr_out (phys_addr_out),
    .hit           (hit),
    .tlb_stall     (tlb_stall),
    .miss_count    (miss_count)
  );

  tlb_assoc #(.PPN_OFFSET(1)) dut_off (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .virt_addr_in  (virt_addr_in),
    .flush         (flush),
    .phys_addr_out (phys2),
    .hit           (hit2),
    .tlb_stall     (stall2),
    .miss_count    (miss_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Holds a request until the stall drops, then checks the translation.
  task automatic do_access(input string tag, input logic [31:0] addr,
                           input int exp_stalls, input logic [31:0] exp_pa,
                           input logic [31:0] exp_pa2);
    int stalls;
    req_valid    = 1'b1;
    virt_addr_in = addr;
    stalls       = 0;
    #1;
    while (tlb_stall && stalls < 40) begin
      stalls++;
      tick(1);
    end
    if (exp_stalls > 0) exp_mc++;
    check({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
    check({tag, ".hit"}, {31'd0, hit}, 32'd1);
    check({tag, ".phys"}, phys_addr_out, exp_pa);
    check({tag, ".phys_off"}, phys2, exp_pa2);
    check({tag, ".miss_count"}, {16'd0, miss_count}, 32'(exp_mc));
    $display("[TB] %s addr=%h stalls=%0d phys=%h phys_off=%h miss_count=%0d",
             tag, addr, stalls, phys_addr_out, phys2, miss_count);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic flush_idle(input string tag);
    flush = 1'b1;
    #1;
    check({tag, ".stall"}, {31'd0, tlb_stall}, 32'd1);
    tick(1);
    flush = 1'b0;
    check({tag, ".miss_count"}, {16'd0, miss_count}, 32'(exp_mc));
    $display("[TB] %s flush in IDLE", tag);
  endtask

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    virt_addr_in = '0;
    flush        = 1'b0;
    tick(2);
    check("reset.hit", {31'd0, hit}, 32'd0);
    check("reset.stall", {31'd0, tlb_stall}, 32'd0);
    check("reset.phys", phys_addr_out, 32'hDEAD_BEEF);
    check("reset.miss_count", {16'd0, miss_count}, 32'd0);
    $display("[TB] reset state");
    reset = 1'b0;
    tick(1);

    do_access("first_miss", 32'h0000_1404, 12, 32'h0000_1404, 32'h0000_1804);
    do_access("off_fill", 32'h0000_0C10, 12, 32'h0000_0C10, 32'h0000_1010);
    do_access("off_hit", 32'h0000_0C3F, 0, 32'h0000_0C3F, 32'h0000_103F);

    flush_idle("flush0");
    for (int p = 1; p <= 4; p++)
      do_access($sformatf("fill_p%0d", p), 32'(p) << 10, 12, 32'(p) << 10, 32'(p + 1) << 10);
    do_access("evict_p5", 32'h0000_1400, 12, 32'h0000_1400, 32'h0000_1800);
    do_access("keep_p2", 32'h0000_0800, 0, 32'h0000_0800, 32'h0000_0C00);
    do_access("refill_p1", 32'h0000_0400, 12, 32'h0000_0400, 32'h0000_0800);
    do_access("keep_p5", 32'h0000_1400, 0, 32'h0000_1400, 32'h0000_1800);
    do_access("refill_p2", 32'h0000_0800, 12, 32'h0000_0800, 32'h0000_0C00);
    do_access("keep_p4", 32'h0000_1000, 0, 32'h0000_1000, 32'h0000_1400);
    do_access("refill_p3", 32'h0000_0C00, 12, 32'h0000_0C00, 32'h0000_1000);

    // Address changes during the walk must not redirect the fill.
    flush_idle("flush1");
    req_valid    = 1'b1;
    virt_addr_in = 32'h0000_0400;
    exp_mc++;
    tick(1);
    virt_addr_in = 32'h0000_8000;
    tick(11);
    check("midwalk.new_hit", {31'd0, hit}, 32'd0);
    check("midwalk.new_stall", {31'd0, tlb_stall}, 32'd1);
    virt_addr_in = 32'h0000_0400;
    #1;
    check("midwalk.old_hit", {31'd0, hit}, 32'd1);
    check("midwalk.old_phys", phys_addr_out, 32'h0000_0400);
    check("midwalk.miss_count", {16'd0, miss_count}, 32'(exp_mc));
    req_valid = 1'b0;
    $display("[TB] midwalk address change hit=%0d phys=%h", hit, phys_addr_out);
    tick(1);

    // Flush aborts a walk at counter 5.
    req_valid    = 1'b1;
    virt_addr_in = 32'h0000_2000;
    exp_mc++;
    tick(6);
    flush = 1'b1;
    #1;
    check("walkflush.stall", {31'd0, tlb_stall}, 32'd1);
    tick(1);
    flush = 1'b0;
    check("walkflush.miss_count", {16'd0, miss_count}, 32'(exp_mc));
    virt_addr_in = 32'h0000_0400;
    #1;
    check("walkflush.cleared", {31'd0, hit}, 32'd0);
    $display("[TB] flush during walk miss_count=%0d", miss_count);
    do_access("after_flush", 32'h0000_2000, 12, 32'h0000_2000, 32'h0000_2400);

    // Reset in the middle of a walk.
    req_valid    = 1'b1;
    virt_addr_in = 32'h0000_3000;
    tick(4);
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    check("midreset.hit", {31'd0, hit}, 32'd0);
    check("midreset.stall", {31'd0, tlb_stall}, 32'd0);
    check("midreset.phys", phys_addr_out, 32'hDEAD_BEEF);
    check("midreset.miss_count", {16'd0, miss_count}, 32'd0);
    $display("[TB] reset during walk");
    tick(2);
    reset  = 1'b0;
    exp_mc = 0;
    req_valid    = 1'b1;
    virt_addr_in = 32'h0000_2000;
    #1;
    check("postreset.hit", {31'd0, hit}, 32'd0);
    do_access("postreset", 32'h0000_2000, 12, 32'h0000_2000, 32'h0000_2400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
